// File: rtl/tictactoe_game_ctrl.sv
// tictactoe_game_ctrl: turn sequencer/arbiter for a 3x3 two-player game; optional per-turn timeout under `MOVE_TIMEOUT_EN
module tictactoe_game_ctrl #(
  parameter bit FIRST_PLAYER   = 1'b0,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       a_valid,
  input  logic [3:0] a_pos,
  output logic       a_ready,
  input  logic       b_valid,
  input  logic [3:0] b_pos,
  output logic       b_ready,
  output logic [8:0] ain,
  output logic [8:0] bin,
  output logic       move_ack,
  output logic       move_err,
  output logic       turn,
  output logic       game_over,
  output logic [1:0] winner,
  output logic [7:0] win_line,
  output logic       timeout
);
  typedef enum logic [2:0] {IDLE, TURN_A, TURN_B, CHECK, DONE} state_t;
  state_t state_q, state_d;
  logic [8:0] ain_q, ain_d, bin_q, bin_d, occ, mb;
  logic [1:0] winner_q, winner_d;
  logic [7:0] win_line_q, win_line_d, lines;
  logic game_over_q, game_over_d, turn_q, turn_d, err_q, err_d;
  logic [15:0] occ_x;
  logic [3:0] pos;
  logic in_turn, mv_valid, legal, accept, expire;
  always_comb begin
    in_turn  = state_q == TURN_A || state_q == TURN_B;
    pos      = state_q == TURN_B ? b_pos : a_pos;
    mv_valid = (state_q == TURN_A && a_valid) || (state_q == TURN_B && b_valid);
    occ      = ain_q | bin_q;
    occ_x    = {7'b0, occ};
    legal    = pos <= 4'd8 && !occ_x[pos];
    accept   = mv_valid && legal;
    mb       = turn_q ? bin_q : ain_q;
    lines    = {mb[2] & mb[4] & mb[6], mb[8] & mb[4] & mb[0],
                mb[6] & mb[3] & mb[0], mb[7] & mb[4] & mb[1], mb[8] & mb[5] & mb[2],
                mb[2] & mb[1] & mb[0], mb[5] & mb[4] & mb[3], mb[8] & mb[7] & mb[6]};
  end
`ifdef MOVE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] T_MAX = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic to_q;
  always_comb begin
    expire = cnt_q == T_MAX;
    cnt_d  = in_turn && !accept && !expire ? cnt_q + CW'(1) : '0;
  end
  always_ff @(posedge clk) begin
    cnt_q <= reset ? '0 : cnt_d;
    to_q  <= !reset && in_turn && !accept && expire;
  end
  assign timeout = to_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^TIMEOUT_CYCLES;
  assign expire     = 1'b0;
  assign timeout    = 1'b0;
`endif
  always_comb begin
    state_d     = state_q;
    ain_d       = ain_q;
    bin_d       = bin_q;
    winner_d    = winner_q;
    win_line_d  = win_line_q;
    game_over_d = game_over_q;
    turn_d      = turn_q;
    err_d       = 1'b0;
    case (state_q)
      IDLE, DONE: if (start) begin
        ain_d       = '0;
        bin_d       = '0;
        winner_d    = 2'b00;
        win_line_d  = '0;
        game_over_d = 1'b0;
        turn_d      = FIRST_PLAYER;
        state_d     = FIRST_PLAYER ? TURN_B : TURN_A;
      end
      TURN_A, TURN_B: begin
        if (mv_valid && !legal) err_d = 1'b1;
        else if (accept) begin
          ain_d   = state_q == TURN_A ? ain_q | (9'd1 << pos) : ain_q;
          bin_d   = state_q == TURN_B ? bin_q | (9'd1 << pos) : bin_q;
          state_d = CHECK;
        end else if (expire) begin
          turn_d  = !turn_q;
          state_d = state_q == TURN_A ? TURN_B : TURN_A;
        end
      end
      CHECK: begin
        // a completed line beats a full board, so a 9th-move win is never a draw
        if (|lines || &occ) begin
          state_d     = DONE;
          game_over_d = 1'b1;
          winner_d    = |lines ? (turn_q ? 2'b10 : 2'b01) : 2'b11;
          win_line_d  = lines;
        end else begin
          turn_d  = !turn_q;
          state_d = turn_q ? TURN_A : TURN_B;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ain_q       <= '0;
      bin_q       <= '0;
      winner_q    <= 2'b00;
      win_line_q  <= '0;
      game_over_q <= 1'b0;
      turn_q      <= FIRST_PLAYER;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ain_q       <= ain_d;
      bin_q       <= bin_d;
      winner_q    <= winner_d;
      win_line_q  <= win_line_d;
      game_over_q <= game_over_d;
      turn_q      <= turn_d;
      err_q       <= err_d;
    end
  end
  assign a_ready   = state_q == TURN_A;
  assign b_ready   = state_q == TURN_B;
  assign move_ack  = state_q == CHECK;
  assign move_err  = err_q;
  assign ain       = ain_q;
  assign bin       = bin_q;
  assign winner    = winner_q;
  assign win_line  = win_line_q;
  assign game_over = game_over_q;
  assign turn      = turn_q;
endmodule

// File: tb/tb_tictactoe_game_ctrl.sv
// tb_tictactoe_game_ctrl: directed self-checking bench; second instance covers B-first start
module tb_tictactoe_game_ctrl;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic a_valid = 1'b0, b_valid = 1'b0;
  logic [3:0] a_pos = '0, b_pos = '0;
  logic a_ready, b_ready, move_ack, move_err, turn, game_over, timeout;
  logic [8:0] ain, bin;
  logic [1:0] winner;
  logic [7:0] win_line;
  logic a_ready1, b_ready1, move_ack1, move_err1, turn1, game_over1, timeout1;
  logic [8:0] ain1, bin1;
  logic [1:0] winner1;
  logic [7:0] win_line1;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  tictactoe_game_ctrl #(.FIRST_PLAYER(1'b0), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .start(start),
    .a_valid(a_valid), .a_pos(a_pos), .a_ready(a_ready),
    .b_valid(b_valid), .b_pos(b_pos), .b_ready(b_ready),
    .ain(ain), .bin(bin), .move_ack(move_ack), .move_err(move_err), .turn(turn),
    .game_over(game_over), .winner(winner), .win_line(win_line), .timeout(timeout));
  tictactoe_game_ctrl #(.FIRST_PLAYER(1'b1), .TIMEOUT_CYCLES(4)) dut1 (
    .clk(clk), .reset(reset), .start(start),
    .a_valid(1'b0), .a_pos(4'd0), .a_ready(a_ready1),
    .b_valid(1'b0), .b_pos(4'd0), .b_ready(b_ready1),
    .ain(ain1), .bin(bin1), .move_ack(move_ack1), .move_err(move_err1), .turn(turn1),
    .game_over(game_over1), .winner(winner1), .win_line(win_line1), .timeout(timeout1));
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, o, e);
    end
  endtask
  task automatic mv(input bit pl, input logic [3:0] p);
    if (!pl) begin a_valid = 1'b1; a_pos = p; end
    else begin b_valid = 1'b1; b_pos = p; end
    tick;
    a_valid = 1'b0;
    b_valid = 1'b0;
    chk("move_ack", move_ack, 1);
    tick;
  endtask
  task automatic go;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask
  initial begin
    tick;
    tick;
    reset = 1'b0;
    chk("rst_ready", {a_ready, b_ready}, 0);
    chk("rst_boards", {ain, bin}, 0);
    chk("rst_outs", {turn, game_over, winner, win_line, move_ack, move_err, timeout}, 0);
    chk("rst_turn_b_first", turn1, 1);
    go;
    chk("start_ready", {a_ready, b_ready, turn}, 3'b100);
    chk("bfirst_ready", {a_ready1, b_ready1, turn1}, 3'b011);
    b_valid = 1'b1; b_pos = 4'd3;
    tick;
    b_valid = 1'b0;
    chk("offturn_ack_err", {move_ack, move_err}, 0);
    chk("offturn_bin", bin, 0);
    chk("offturn_ready", a_ready, 1);
    mv(0, 8); mv(1, 0); mv(0, 7); mv(1, 1); mv(0, 6);
    chk("t1_over", game_over, 1);
    chk("t1_winner", winner, 2'b01);
    chk("t1_line", win_line, 8'h01);
    chk("t1_ain", ain, 9'h1C0);
    chk("t1_bin", bin, 9'h003);
    chk("t1_ready", {a_ready, b_ready, move_ack}, 0);
    a_valid = 1'b1; a_pos = 4'd2;
    tick;
    tick;
    a_valid = 1'b0;
    chk("done_hold", {game_over, winner, win_line, ain}, {1'b1, 2'b01, 8'h01, 9'h1C0});
    go;
    chk("restart_clear", {game_over, winner, win_line, ain, bin}, 0);
    mv(0, 4);
    b_valid = 1'b1; b_pos = 4'd4;
    tick;
    chk("occ_err", {move_err, move_ack}, 2'b10);
    chk("occ_bin", bin, 0);
    chk("occ_ready", b_ready, 1);
    b_pos = 4'd9;
    tick;
    chk("range_err", {move_err, b_ready, bin}, {1'b1, 1'b1, 9'h000});
    b_pos = 4'd0;
    tick;
    b_valid = 1'b0;
    chk("legal_ack", {move_ack, move_err}, 2'b10);
    tick;
    chk("legal_bin", {bin, a_ready, turn}, {9'h001, 1'b1, 1'b0});
    go;
    chk("midgame_start", {ain, bin, a_ready, turn}, {9'h010, 9'h001, 1'b1, 1'b0});
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("midgame_reset", {ain, bin, a_ready, b_ready, game_over}, 0);
    go;
    mv(0, 4); mv(1, 0); mv(0, 8); mv(1, 2); mv(0, 1); mv(1, 7); mv(0, 6); mv(1, 5); mv(0, 3);
    chk("draw_winner", {game_over, winner}, 3'b111);
    chk("draw_line", win_line, 0);
    chk("draw_boards", {ain, bin}, {9'h15A, 9'h0A5});
    go;
    mv(0, 7); mv(1, 2); mv(0, 1); mv(1, 3); mv(0, 8); mv(1, 5); mv(0, 0); mv(1, 6); mv(0, 4);
    chk("win9_winner", {game_over, winner}, 3'b101);
    chk("win9_line", win_line, 8'h50);
    chk("win9_boards", {ain, bin}, {9'h193, 9'h06C});
    go;
    mv(0, 0); mv(1, 3); mv(0, 1); mv(1, 4); mv(0, 8); mv(1, 5);
    chk("bwin", {game_over, winner, win_line}, {1'b1, 2'b10, 8'h02});
    go;
`ifdef MOVE_TIMEOUT_EN
    tick;
    tick;
    tick;
    chk("to_wait", {timeout, a_ready, turn}, 3'b010);
    tick;
    chk("to_pulse", {timeout, b_ready, turn}, 3'b111);
    chk("to_board", ain, 0);
    tick;
    chk("to_clear", timeout, 0);
    tick;
    tick;
    b_valid = 1'b1; b_pos = 4'd0;
    tick;
    b_valid = 1'b0;
    chk("to_accept_last", {timeout, move_ack, bin}, {1'b0, 1'b1, 9'h001});
    tick;
    chk("to_next_turn", {a_ready, turn}, 2'b10);
`else
    for (int i = 0; i < 10; i++) begin
      tick;
      chk("no_timeout", timeout, 0);
    end
    chk("wait_forever", {a_ready, turn}, 2'b10);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
